// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline-control definitions for the RV32IM 5-stage pipeline.
// Contents:
//   div_state_e          - divide-occupancy FSM encoding (RUN / DIV_WAIT)
//   DIV_LATENCY_DEFAULT  - default number of cycles a DIV/REM spends in EXE
//   NOP_INSN             - instruction word that flush/bubble consumers load
package pipeline_ctrl_pkg;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_DIV_WAIT = 1'b1
    } div_state_e;

    localparam int DIV_LATENCY_DEFAULT = 32;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSN = 32'h00000013;

endpackage

// File: rtl/reg_hazard_match.sv
// x0-aware register dependency compare.
// Ports:
//   id_addr  in  5  source register of the instruction in ID
//   id_use   in  1  the ID instruction actually reads id_addr
//   exe_addr in  5  destination register of the instruction in EXE
//   hit      out 1  ID depends on the EXE result (never for x0)
module reg_hazard_match
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] id_addr,
    input  logic       id_use,
    input  logic [4:0] exe_addr,
    output logic       hit
);

    // x0 is hardwired to zero, so writes to it create no dependency.
    assign hit = id_use && (id_addr == exe_addr) && (exe_addr != 5'd0);

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall / flush / bubble controller for the RV32IM 5-stage pipeline.
// Decides when the pipeline must wait rather than forward: load-use hazards,
// multi-cycle divide occupancy of EXE, memory wait states and taken branches.
// Ports:
//   CLK, RESET                 clock (rising edge), async active-low reset
//   ADDR1/ADDR2, USE1/USE2     ID source registers and their use qualifiers
//   EXE_ADDR, EXE_MEM_READ     EXE destination register, EXE is a load
//   EXE_DIV                    EXE holds a DIV/DIVU/REM/REMU
//   BRANCH_TAKEN               EXE resolved a taken branch/jump
//   INST_MEM_BUSY/DATA_MEM_BUSY memory wait states
//   *_STALL, IF_ID_FLUSH, *_BUBBLE  per-register pipeline controls
//   DIV_BUSY                   divide FSM is in DIV_WAIT
//   STALL_COUNT                cycles with PC_STALL high since reset
module hazard_stall_unit
    import pipeline_ctrl_pkg::*;
#(
    parameter int DIV_LATENCY = DIV_LATENCY_DEFAULT,
    parameter int PERF_WIDTH  = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [4:0]            ADDR1,
    input  logic [4:0]            ADDR2,
    input  logic                  USE1,
    input  logic                  USE2,
    input  logic [4:0]            EXE_ADDR,
    input  logic                  EXE_MEM_READ,
    input  logic                  EXE_DIV,
    input  logic                  BRANCH_TAKEN,
    input  logic                  INST_MEM_BUSY,
    input  logic                  DATA_MEM_BUSY,
    output logic                  PC_STALL,
    output logic                  IF_ID_STALL,
    output logic                  ID_EXE_STALL,
    output logic                  EXE_MEM_STALL,
    output logic                  MEM_WB_STALL,
    output logic                  IF_ID_FLUSH,
    output logic                  ID_EXE_BUBBLE,
    output logic                  EXE_MEM_BUBBLE,
    output logic                  DIV_BUSY,
    output logic [PERF_WIDTH-1:0] STALL_COUNT
);

    localparam int CNT_W = (DIV_LATENCY > 2) ? $clog2(DIV_LATENCY) : 1;
    // The RUN cycle that launches the divide is the first stall cycle, so the
    // wait counter covers the remaining DIV_LATENCY-2 stall cycles.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_LATENCY - 2);

    div_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [PERF_WIDTH-1:0] stall_count_q, stall_count_d;

    logic [1:0][4:0] id_addr;
    logic [1:0]      id_use;
    logic [1:0]      match;

    assign id_addr = {ADDR2, ADDR1};
    assign id_use  = {USE2, USE1};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_match
            reg_hazard_match u_match (
                .id_addr  (id_addr[gi]),
                .id_use   (id_use[gi]),
                .exe_addr (EXE_ADDR),
                .hit      (match[gi])
            );
        end
    endgenerate

    logic load_use;
    logic div_stall;
    // Raw control vector: {pc, if_id, id_exe, exe_mem, mem_wb stalls,
    //                      if_id flush, id_exe bubble, exe_mem bubble}
    logic [7:0] ctrl;

    assign load_use  = EXE_MEM_READ && (match != 2'b00);
    assign div_stall = ((state_q == ST_RUN) && EXE_DIV) ||
                       ((state_q == ST_DIV_WAIT) && (cnt_q != '0));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl    = 8'b0;

        if (DATA_MEM_BUSY) begin
            // Freeze everything, including the divide FSM.
            ctrl = 8'b1111_1000;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (EXE_DIV) begin
                        state_d = ST_DIV_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
                ST_DIV_WAIT: begin
                    if (cnt_q == '0) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: state_d = ST_RUN;
            endcase

            if (div_stall) begin
                ctrl = 8'b1110_0001;
            end else if (BRANCH_TAKEN) begin
                // The squashed instruction cannot hazard, so flush wins.
                ctrl = 8'b0000_0110;
            end else if (load_use || INST_MEM_BUSY) begin
                ctrl = 8'b1100_0010;
            end
        end
    end

    // Controls are held inactive for as long as reset is asserted.
    assign {PC_STALL, IF_ID_STALL, ID_EXE_STALL, EXE_MEM_STALL, MEM_WB_STALL,
            IF_ID_FLUSH, ID_EXE_BUBBLE, EXE_MEM_BUBBLE} = RESET ? ctrl : 8'b0;
    assign DIV_BUSY    = RESET && (state_q == ST_DIV_WAIT);
    assign STALL_COUNT = stall_count_q;

    always_comb begin
        stall_count_d = stall_count_q;
        if (PC_STALL) begin
            stall_count_d = stall_count_q + PERF_WIDTH'(1);
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q       <= ST_RUN;
            cnt_q         <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;

    logic        clk;
    logic        rst_n;
    logic [4:0]  addr1, addr2, exe_addr;
    logic        use1, use2, exe_mem_read, exe_div, branch_taken;
    logic        inst_mem_busy, data_mem_busy;
    logic        pc_stall, if_id_stall, id_exe_stall, exe_mem_stall, mem_wb_stall;
    logic        if_id_flush, id_exe_bubble, exe_mem_bubble, div_busy;
    logic [31:0] stall_count;

    hazard_stall_unit #(
        .DIV_LATENCY (4),
        .PERF_WIDTH  (32)
    ) dut (
        .CLK            (clk),
        .RESET          (rst_n),
        .ADDR1          (addr1),
        .ADDR2          (addr2),
        .USE1           (use1),
        .USE2           (use2),
        .EXE_ADDR       (exe_addr),
        .EXE_MEM_READ   (exe_mem_read),
        .EXE_DIV        (exe_div),
        .BRANCH_TAKEN   (branch_taken),
        .INST_MEM_BUSY  (inst_mem_busy),
        .DATA_MEM_BUSY  (data_mem_busy),
        .PC_STALL       (pc_stall),
        .IF_ID_STALL    (if_id_stall),
        .ID_EXE_STALL   (id_exe_stall),
        .EXE_MEM_STALL  (exe_mem_stall),
        .MEM_WB_STALL   (mem_wb_stall),
        .IF_ID_FLUSH    (if_id_flush),
        .ID_EXE_BUBBLE  (id_exe_bubble),
        .EXE_MEM_BUBBLE (exe_mem_bubble),
        .DIV_BUSY       (div_busy),
        .STALL_COUNT    (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control bit order: pc, ifid, idexe, exemem, memwb, flush, idbub, exbub, divbusy
    localparam logic [8:0] C_NONE  = 9'b00000_000_0;
    localparam logic [8:0] C_LU    = 9'b11000_010_0;  // load-use / inst busy
    localparam logic [8:0] C_DIV   = 9'b11100_001_0;
    localparam logic [8:0] C_FRZ   = 9'b11111_000_0;
    localparam logic [8:0] C_BR    = 9'b00000_110_0;
    localparam logic [8:0] C_BUSY  = 9'b00000_000_1;
    localparam logic [8:0] M_ALL   = 9'h1FF;
    localparam logic [8:0] M_NODB  = 9'h1FE;           // ignore DIV_BUSY

    typedef struct {
        string      tag;
        logic [8:0] ctrl;
        logic [8:0] mask;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic [31:0] exp_cnt = 0;

    function automatic logic [8:0] obs_ctrl();
        return {pc_stall, if_id_stall, id_exe_stall, exe_mem_stall, mem_wb_stall,
                if_id_flush, id_exe_bubble, exe_mem_bubble, div_busy};
    endfunction

    task automatic idle_inputs();
        addr1 = 5'd0; addr2 = 5'd0; exe_addr = 5'd0;
        use1 = 1'b0; use2 = 1'b0; exe_mem_read = 1'b0; exe_div = 1'b0;
        branch_taken = 1'b0; inst_mem_busy = 1'b0; data_mem_busy = 1'b0;
    endtask

    task automatic push(input string tag, input logic [8:0] ctrl, input logic [8:0] mask);
        exp_t e;
        e.tag  = tag;
        e.ctrl = ctrl;
        e.mask = mask;
        e.cnt  = exp_cnt;
        exp_q.push_back(e);
        // Expected counter tracks the cycles the bench expects PC_STALL high.
        if (ctrl[8]) exp_cnt = exp_cnt + 1;
    endtask

    task automatic pop_check();
        exp_t e;
        logic [8:0] o;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=0 entries required=1");
            return;
        end
        e = exp_q.pop_front();
        o = obs_ctrl();
        checks++;
        assert ((o & e.mask) === (e.ctrl & e.mask)) else begin
            errors++;
            $error("FAIL %s ctrl observed=%b required=%b mask=%b", e.tag, o, e.ctrl, e.mask);
        end
        checks++;
        assert (stall_count === e.cnt) else begin
            errors++;
            $error("FAIL %s stall_count observed=%0d required=%0d", e.tag, stall_count, e.cnt);
        end
        $display("step %-14s ctrl=%b cnt=%0d", e.tag, o, stall_count);
    endtask

    // Drive one cycle's inputs just after the rising edge, check before the next.
    task automatic cycle(input string tag, input logic [8:0] ctrl, input logic [8:0] mask);
        push(tag, ctrl, mask);
        @(negedge clk);
        pop_check();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        // Hazard-looking inputs during reset must not leak through.
        exe_div = 1'b1; exe_mem_read = 1'b1; exe_addr = 5'd5; addr1 = 5'd5; use1 = 1'b1;
        inst_mem_busy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        push("reset", C_NONE, M_ALL);
        @(negedge clk);
        pop_check();
        #2 rst_n = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;

        cycle("idle", C_NONE, M_ALL);

        // Load-use on rs1, then bubble clears the load.
        exe_mem_read = 1'b1; exe_addr = 5'd5; addr1 = 5'd5; use1 = 1'b1;
        cycle("lu_rs1", C_LU, M_ALL);
        exe_mem_read = 1'b0;
        cycle("lu_after", C_NONE, M_ALL);

        // x0 never hazards.
        exe_mem_read = 1'b1; exe_addr = 5'd0; addr1 = 5'd0; use1 = 1'b1;
        cycle("lu_x0", C_NONE, M_ALL);
        // Matching rs2 that is not used.
        exe_addr = 5'd5; addr1 = 5'd7; addr2 = 5'd5; use2 = 1'b0;
        cycle("lu_rs2_unused", C_NONE, M_ALL);
        use2 = 1'b1;
        cycle("lu_rs2", C_LU, M_ALL);
        idle_inputs();
        cycle("idle2", C_NONE, M_ALL);

        // Divide, latency 4: three stall cycles then release.
        exe_div = 1'b1;
        cycle("div_c1", C_DIV, M_ALL);
        cycle("div_c2", C_DIV | C_BUSY, M_ALL);
        cycle("div_c3", C_DIV | C_BUSY, M_ALL);
        cycle("div_release", C_NONE, M_NODB);
        exe_div = 1'b0;
        cycle("div_done", C_NONE, M_ALL);

        // Divide with a data-memory freeze while the counter sits at 1.
        exe_div = 1'b1;
        cycle("divf_c1", C_DIV, M_ALL);
        cycle("divf_c2", C_DIV | C_BUSY, M_ALL);
        data_mem_busy = 1'b1;
        cycle("divf_frz1", C_FRZ | C_BUSY, M_ALL);
        cycle("divf_frz2", C_FRZ | C_BUSY, M_ALL);
        data_mem_busy = 1'b0;
        cycle("divf_c3", C_DIV | C_BUSY, M_ALL);
        cycle("divf_release", C_NONE, M_NODB);
        exe_div = 1'b0;
        cycle("divf_done", C_NONE, M_ALL);

        // Taken branch beats load-use and instruction-memory wait.
        branch_taken = 1'b1; exe_mem_read = 1'b1; exe_addr = 5'd9;
        addr1 = 5'd9; use1 = 1'b1; inst_mem_busy = 1'b1;
        cycle("branch_prio", C_BR, M_ALL);
        idle_inputs();
        inst_mem_busy = 1'b1;
        cycle("imem_busy", C_LU, M_ALL);
        inst_mem_busy = 1'b0;

        // Divide ignores a simultaneous branch; reset it mid-DIV_WAIT.
        exe_div = 1'b1; branch_taken = 1'b1;
        cycle("div_vs_branch", C_DIV, M_ALL);
        branch_taken = 1'b0;
        push("div_wait_pre", C_DIV | C_BUSY, M_ALL);
        @(negedge clk);
        pop_check();
        #2 rst_n = 1'b0;
        exp_cnt = 0;
        #1;
        push("async_reset", C_NONE, M_ALL);
        pop_check();
        @(negedge clk);
        #2 rst_n = 1'b1;
        exe_div = 1'b0;
        @(posedge clk);
        #1;
        cycle("post_reset", C_NONE, M_ALL);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
